dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core load/store path (port 0) and a debug/DMA master (port 1). It sits between the core datapath and DMEM. It grants at most one requester per cycle and supports locked bursts. It returns read data one cycle after the grant, tagged to the granted port, and raises a stall to the core whenever the core requests but is not granted.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LOCK_MAX`, 8: maximum consecutive locked grants before a lock is forcibly broken (≥1).
- `STARVE_LIMIT`, 4: in fixed-priority mode, the number of consecutive denied cycles for port 1 before it is force-granted (≥1).

Ports:
- `clk` in 1: the only clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: access request, port 0 / port 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in AW: byte address.
- `wdata0`, `wdata1` in DW: write data.
- `lock0`, `lock1` in 1: hold the grant for the next cycle.
- `gnt0`, `gnt1` out 1: grant, combinational, one-hot or zero.
- `rvalid0`, `rvalid1` out 1: read data valid for the port.
- `rdata` out DW: read data, shared bus.
- `core_stall` out 1: `req0 & ~gnt0`.
- `mem_en`, `mem_we` out 1: memory strobe / write enable.
- `mem_addr` out AW, `mem_wdata` out DW: muxed from the granted port.
- `mem_rdata` in DW: memory read data, valid one cycle after `mem_en & ~mem_we`.

## Operation
- States: `ARB`, `LOCK0`, `LOCK1`.
- In `ARB`, the grant goes to the winner among the active requests:
  - Only one request active: that port wins.
  - Both active: the winner is set by the arbitration mode (see Configuration).
- A grant of port p with `lockp=1` moves to `LOCKp`.
- In `LOCKp`:
  - Only port p can be granted; the other port's request is held off.
  - Exit to `ARB` when port p is granted with `lockp=0`, or when `reqp=0` (no grant that cycle, and the other port is arbitrated in the same cycle).
  - Also exit to `ARB` when the lock counter reaches `LOCK_MAX`. That grant still completes, and the next cycle arbitrates normally.
- The lock counter clears on entry to `LOCKp` and increments on each locked grant.
- Memory strobe: `mem_en = gnt0|gnt1`. `mem_we`, `mem_addr` and `mem_wdata` come from the granted port. With no grant, `mem_en=0`, `mem_we=0`, and addr/wdata are 0.
- The response register captures `{valid = grant & ~we, owner}` each cycle.
- `rvalidp = valid & (owner==p)`, and `rdata = mem_rdata` while valid; otherwise `rdata = 0`.
- Writes have no response.
- Starvation counter:
  - Increments each cycle that `req1=1` and `gnt1=0` while in `ARB`.
  - Clears on `gnt1` or when `req1=0`.
  - Saturates at `STARVE_LIMIT`.

## Timing
- A grant is combinational in cycle N, and the memory access is issued in cycle N.
- A read granted in N has `rvalid` and `rdata` in N+1, giving one cycle of read latency.
- Back-to-back grants are allowed every cycle. The response pipeline accepts one read per cycle with no bubbles.
- Reset values (during `reset=1`):
  - All `gnt`, `mem_en`, `mem_we` = 0.
  - `rvalid0`/`rvalid1` = 0, `rdata` = 0, `core_stall` = `req0`.
  - State `ARB`; counters 0; round-robin pointer set so that port 0 wins the first tie.
- Reset asserted mid-burst drops the lock. A read that was in flight does not produce `rvalid` in the following cycle.
- Simultaneous requests in `ARB` with one port locked-requesting: normal arbitration applies, and the lock is only honoured for the winner.
- A request dropped on the same cycle the lock would begin creates no lock state.

## Configuration
Macro: `DMEM_ARB_RR_EN`.
- Defined (round robin):
  - On a tie, the port not granted most recently wins.
  - The pointer updates on every `ARB`-state grant.
  - The starvation counter is not implemented, and `STARVE_LIMIT` is ignored.
- Undefined (fixed priority):
  - Port 0 wins ties.
  - When the starvation counter equals `STARVE_LIMIT`, port 1 wins the next tie, and the counter clears.

## Structure
- Package `dmem_arb_pkg` holds:
  - `arb_state_t` enum {`ARB`, `LOCK0`, `LOCK1`}.
  - `port_t` (1-bit owner).
  - Request struct `arb_req_t` {req, we, lock, addr, wdata}.
- One sub-module, `dmem_arb_resp`: the read-response register (valid and owner) plus the rvalid/rdata demux.

## Test plan
- Single read on port 0 to 0x100, memory returns 0xDEADBEEF: `gnt0` in N, then `rvalid0=1` and `rdata=0xDEADBEEF` in N+1, with `rvalid1=0`.
- Both ports request every cycle:
  - RR build: the grant alternates 0,1,0,1.
  - Fixed build, `STARVE_LIMIT=4`: the pattern is 0,0,0,0,1,0,0,0,0,1, and `core_stall=1` only on the port-1 cycles.
- Port 1 writes a 3-beat burst with `lock1`=1,1,0 while port 0 requests throughout: `gnt1` for 3 cycles, `core_stall=1` for those 3 cycles, then `gnt0`.
- Port 0 holds `lock0=1` for 20 cycles with `LOCK_MAX=8` while port 1 requests: the lock breaks after 8 grants, and port 1 is granted by tie rule within 1 cycle (RR), or after the starvation limit (fixed).
- `reset` pulsed the cycle after a granted read in a locked burst: no `rvalid`, state `ARB`, and all outputs 0 during reset.
- No requests for 5 cycles: `mem_en=0`, `mem_we=0`, `mem_addr=0`, and both `rvalid`=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Build option DMEM_ARB_RR_EN selects round-robin tie breaking.
package dmem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        ARB,
        LOCK0,
        LOCK1
    } arb_state_t;

    typedef logic port_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic              lock;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } arb_req_t;

    // Returns {gnt1, gnt0}; pref1 decides a tie.
    function automatic logic [1:0] arb_pick(
        input logic r0,
        input logic r1,
        input logic pref1
    );
        logic [1:0] g;
        g = 2'b00;
        if (r0 && r1)
            g = pref1 ? 2'b10 : 2'b01;
        else if (r0)
            g = 2'b01;
        else if (r1)
            g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// Read-response register and per-port rvalid/rdata demux.
// One cycle of latency from grant to rvalid.
module dmem_arb_resp
    import dmem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_valid,
    input  port_t         cap_owner,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata
);

    logic  valid;
    port_t owner;
    logic  live;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            owner <= 1'b0;
        end else begin
            valid <= cap_valid;
            owner <= cap_owner;
        end
    end

    // A read still in flight when reset rises is squashed.
    assign live    = valid & ~reset;
    assign rvalid0 = live & (owner == 1'b0);
    assign rvalid1 = live & (owner == 1'b1);
    assign rdata   = live ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter with locked bursts and tagged read return.
// DMEM_ARB_RR_EN: round-robin ties; otherwise fixed priority + anti-starve.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int LOCK_MAX     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          core_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    arb_req_t   r0;
    arb_req_t   r1;
    arb_state_t state;
    logic [LCW-1:0] lock_cnt;
    logic       pref1;
    logic       hold;
    logic       lk;
    logic       g0;
    logic       g1;

    assign r0 = '{req: req0, we: we0, lock: lock0,
                  addr: ARB_AW'(addr0), wdata: ARB_DW'(wdata0)};
    assign r1 = '{req: req1, we: we1, lock: lock1,
                  addr: ARB_AW'(addr1), wdata: ARB_DW'(wdata1)};

`ifdef DMEM_ARB_RR_EN
    port_t last;

    assign pref1 = (last == 1'b0);

    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (!hold && (g0 || g1))
            last <= g1;
    end
`else
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve;

    assign pref1 = (starve == SCW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset)
            starve <= '0;
        else if (!r1.req || g1)
            starve <= '0;
        else if (state == ARB && !pref1)
            starve <= starve + SCW'(1);
    end
`endif

    always_comb begin
        hold = (state == LOCK0 && r0.req) ||
               (state == LOCK1 && r1.req);
        lk   = (state == LOCK0) ? r0.lock : r1.lock;
        if (reset)
            {g1, g0} = 2'b00;
        else if (state == LOCK0 && r0.req)
            {g1, g0} = 2'b01;
        else if (state == LOCK1 && r1.req)
            {g1, g0} = 2'b10;
        else
            {g1, g0} = arb_pick(r0.req, r1.req, pref1);
    end

    assign gnt0       = g0;
    assign gnt1       = g1;
    assign core_stall = req0 & ~g0;
    assign mem_en     = g0 | g1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (g0) begin
            mem_we    = r0.we;
            mem_addr  = AW'(r0.addr);
            mem_wdata = DW'(r0.wdata);
        end else if (g1) begin
            mem_we    = r1.we;
            mem_addr  = AW'(r1.addr);
            mem_wdata = DW'(r1.wdata);
        end
    end

    // lock_cnt counts grants of the current burst, entry grant included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            lock_cnt <= '0;
        end else if (hold) begin
            if (!lk || lock_cnt == LCW'(LOCK_MAX - 1)) begin
                state    <= ARB;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + LCW'(1);
            end
        end else if (g0 && r0.lock && LOCK_MAX > 1) begin
            state    <= LOCK0;
            lock_cnt <= LCW'(1);
        end else if (g1 && r1.lock && LOCK_MAX > 1) begin
            state    <= LOCK1;
            lock_cnt <= LCW'(1);
        end else begin
            state    <= ARB;
            lock_cnt <= '0;
        end
    end

    dmem_arb_resp #(
        .DW(DW)
    ) u_resp (
        .clk       (clk),
        .reset     (reset),
        .cap_valid (mem_en & ~mem_we),
        .cap_owner (g1),
        .mem_rdata (mem_rdata),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level reference model.
// Honours DMEM_ARB_RR_EN the same way as the design.
module tb_dmem_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int LOCK_MAX     = 8;
    localparam int STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, core_stall;
    logic          mem_en, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    // reference model state
    int lk_owner = -1;
    int lk_run   = 0;
    int starve   = 0;
    int last_g   = 1;
    bit pv       = 0;
    int pown     = 0;
    logic [31:0] paddr = '0;

    // observed values of the most recent step
    logic o_g0, o_g1, o_stall, o_rv0, o_rv1, o_en;
    logic [31:0] o_rdata, o_addr;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .core_stall(core_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h100)
            return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // memory: returns data one cycle after a read strobe, junk otherwise
    always @(posedge clk)
        mem_rdata <= (mem_en && !mem_we) ? rd_fn(mem_addr) : $urandom;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic step();
        bit rq[2], wr[2], lk[2];
        logic [31:0] ad[2], wd[2];
        int eg;
        rq[0] = req0;  rq[1] = req1;
        wr[0] = we0;   wr[1] = we1;
        lk[0] = lock0; lk[1] = lock1;
        ad[0] = addr0; ad[1] = addr1;
        wd[0] = wdata0; wd[1] = wdata1;
        #1;
        eg = -1;
        if (reset)
            eg = -1;
        else if (lk_owner >= 0 && rq[lk_owner])
            eg = lk_owner;
        else if (rq[0] && rq[1]) begin
`ifdef DMEM_ARB_RR_EN
            eg = 1 - last_g;
`else
            eg = (starve == STARVE_LIMIT) ? 1 : 0;
`endif
        end else if (rq[0])
            eg = 0;
        else if (rq[1])
            eg = 1;

        chk("gnt0", gnt0, eg == 0);
        chk("gnt1", gnt1, eg == 1);
        chk("stall", core_stall, rq[0] && eg != 0);
        chk("mem_en", mem_en, eg >= 0);
        chk("mem_we", mem_we, (eg >= 0) ? wr[eg] : 1'b0);
        chk("mem_addr", mem_addr, (eg >= 0) ? ad[eg] : 32'd0);
        chk("mem_wdata", mem_wdata, (eg >= 0) ? wd[eg] : 32'd0);
        chk("rvalid0", rvalid0, pv && !reset && pown == 0);
        chk("rvalid1", rvalid1, pv && !reset && pown == 1);
        chk("rdata", rdata, (pv && !reset) ? rd_fn(paddr) : 32'd0);
        o_g0 = gnt0; o_g1 = gnt1; o_stall = core_stall;
        o_rv0 = rvalid0; o_rv1 = rvalid1; o_rdata = rdata;
        o_en = mem_en; o_addr = mem_addr;

        @(posedge clk);
        if (reset) begin
            lk_owner = -1; lk_run = 0; starve = 0; last_g = 1; pv = 0;
        end else begin
            if (!rq[1] || eg == 1)
                starve = 0;
            else if (lk_owner < 0 && starve < STARVE_LIMIT)
                starve++;
            if (lk_owner >= 0 && eg == lk_owner) begin
                lk_run++;
                if (!lk[eg] || lk_run >= LOCK_MAX)
                    lk_owner = -1;
            end else begin
                if (eg >= 0)
                    last_g = eg;
                if (eg >= 0 && lk[eg] && LOCK_MAX > 1) begin
                    lk_owner = eg;
                    lk_run   = 1;
                end else begin
                    lk_owner = -1;
                end
            end
            pv    = (eg >= 0) && !wr[eg];
            pown  = eg;
            paddr = (eg >= 0) ? ad[eg] : 32'd0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        for (int i = 0; i < n; i++)
            step();
        reset = 0;
    endtask

    initial begin
        int first;
        bit exp1;
        idle_in();
        reset = 1;
        @(negedge clk);
        req0 = 1; req1 = 1;
        do_reset(2);
        idle_in();

        // single read on port 0
        req0 = 1; addr0 = 32'h100;
        step();
        chk("rd_gnt0", o_g0, 1);
        idle_in();
        step();
        chk("rd_rvalid0", o_rv0, 1);
        chk("rd_rdata", o_rdata, 32'hDEADBEEF);
        chk("rd_rvalid1", o_rv1, 0);

        // both ports request every cycle
        do_reset(1);
        req0 = 1; req1 = 1; addr0 = 32'h40; addr1 = 32'h80;
        for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp1 = (i % 2 == 1);
`else
            exp1 = (i % (STARVE_LIMIT + 1) == STARVE_LIMIT);
`endif
            step();
            chk("tie_gnt1", o_g1, exp1);
            chk("tie_stall", o_stall, exp1);
        end

        // port 1 locked write burst while port 0 waits
        idle_in();
        do_reset(1);
`ifdef DMEM_ARB_RR_EN
        req0 = 1;
        step();
`else
        req0 = 1; req1 = 1;
        for (int i = 0; i < STARVE_LIMIT; i++)
            step();
`endif
        req0 = 1; req1 = 1; we1 = 1; addr1 = 32'h200;
        for (int i = 0; i < 3; i++) begin
            lock1  = (i < 2);
            wdata1 = 32'hA000 + i;
            step();
            chk("burst_gnt1", o_g1, 1);
            chk("burst_stall", o_stall, 1);
        end
        req1 = 0; lock1 = 0; we1 = 0;
        step();
        chk("burst_gnt0", o_g0, 1);

        // port 0 holds lock for a long time, port 1 keeps asking
        idle_in();
        do_reset(1);
        req0 = 1; lock0 = 1; req1 = 1; addr0 = 32'h300; addr1 = 32'h304;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_g1 && first == 0)
                first = i;
        end
`ifdef DMEM_ARB_RR_EN
        chk("lock_break", first, LOCK_MAX + 1);
`else
        chk("lock_break", first, LOCK_MAX * STARVE_LIMIT + 1);
`endif

        // reset in the middle of a locked read burst
        idle_in();
        do_reset(1);
        req0 = 1; lock0 = 1; addr0 = 32'h400;
        step();
        addr0 = 32'h404;
        step();
        req1 = 1;
        reset = 1;
        step();
        chk("rst_gnt0", o_g0, 0);
        chk("rst_rvalid0", o_rv0, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_mem_en", o_en, 0);
        reset = 0;
        req0 = 0; lock0 = 0;
        step();
        chk("post_rst_rvalid0", o_rv0, 0);
        chk("post_rst_gnt1", o_g1, 1);

        // idle
        idle_in();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_mem_en", o_en, 0);
            chk("idle_addr", o_addr, 0);
        end

        // randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 59) == 0);
            req0   = ($urandom_range(0, 9) < 7);
            req1   = ($urandom_range(0, 9) < 6);
            we0    = ($urandom_range(0, 9) < 3);
            we1    = ($urandom_range(0, 9) < 3);
            lock0  = ($urandom_range(0, 9) < 6);
            lock1  = ($urandom_range(0, 9) < 6);
            addr0  = $urandom & 32'hFFFF_FFFC;
            addr1  = $urandom & 32'hFFFF_FFFC;
            wdata0 = $urandom;
            wdata1 = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
